// File: rtl/data_tape_if.sv
// Command/response bundle between the BeeF core and its data tape memory.
// The core drives the master side; the tape memory implements the slave side.
interface data_tape_if #(
    parameter int AW = 8,
    parameter int DW = 8
) ();
  logic          clear_req;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [1:0]    cmd_op;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_data;
  logic [DW-1:0] rd_data;
  logic          rd_valid;
  logic          rd_zero;
  logic          busy;

  modport master (
    output clear_req, cmd_valid, cmd_op, cmd_addr, cmd_data,
    input  cmd_ready, rd_data, rd_valid, rd_zero, busy
  );

  modport slave (
    input  clear_req, cmd_valid, cmd_op, cmd_addr, cmd_data,
    output cmd_ready, rd_data, rd_valid, rd_zero, busy
  );
endinterface

// File: rtl/data_tape_mem.sv
// BeeF data tape: clear sweep after reset or on request, registered reads, and a
// one-command read-modify-write ADD with result forwarding to the next command.
module data_tape_mem #(
    parameter int            AW       = 8,
    parameter int            DW       = 8,
    parameter logic [DW-1:0] INIT_VAL = {DW{1'b0}}
) (
  input  logic       clk,
  input  logic       rst_n,
  data_tape_if.slave bus
);
  localparam int         DEPTH    = 1 << AW;
  localparam logic [1:0] OP_READ  = 2'b01;
  localparam logic [1:0] OP_WRITE = 2'b10;
  localparam logic [1:0] OP_ADD   = 2'b11;

  typedef enum logic {ST_CLEAR = 1'b0, ST_RUN = 1'b1} state_t;

  state_t        state_q;
  logic [AW-1:0] sweep_cnt_q;
  logic [DW-1:0] rd_data_q;
  logic [DW-1:0] rd_data_d;
  logic          rd_valid_q;
  logic          rd_valid_d;
  logic          rd_zero_q;
  logic          pend_q;
  logic [AW-1:0] pend_addr_q;
  logic [DW-1:0] mem_q [DEPTH];

  logic          accept_s;
  logic          fwd_s;
  logic [DW-1:0] operand_s;

  assign bus.cmd_ready = (state_q == ST_RUN);
  assign bus.busy      = (state_q == ST_CLEAR);
  assign bus.rd_data   = rd_data_q;
  assign bus.rd_valid  = rd_valid_q;
  assign bus.rd_zero   = rd_zero_q;

  // Command acceptance, ADD-result forwarding and next read-result value.
  always_comb begin
    accept_s   = bus.cmd_valid & (state_q == ST_RUN) & ~bus.clear_req;
    fwd_s      = pend_q & (pend_addr_q == bus.cmd_addr);
    rd_data_d  = rd_data_q;
    rd_valid_d = 1'b0;
    // The previous ADD has not been written back yet; its result lives in rd_data_q.
    if (fwd_s) begin
      operand_s = rd_data_q;
    end else begin
      operand_s = mem_q[bus.cmd_addr];
    end
    if (accept_s) begin
      case (bus.cmd_op)
        OP_READ: begin
          rd_data_d  = operand_s;
          rd_valid_d = 1'b1;
        end
        OP_ADD: begin
          rd_data_d  = operand_s + bus.cmd_data;
          rd_valid_d = 1'b1;
        end
        default: begin
          rd_data_d  = rd_data_q;
          rd_valid_d = 1'b0;
        end
      endcase
    end else begin
      rd_valid_d = 1'b0;
    end
  end

  // Control FSM, sweep counter, read result and pending-ADD tracking.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_CLEAR;
      sweep_cnt_q <= {AW{1'b0}};
      rd_data_q   <= {DW{1'b0}};
      rd_valid_q  <= 1'b0;
      rd_zero_q   <= 1'b1;
      pend_q      <= 1'b0;
      pend_addr_q <= {AW{1'b0}};
    end else begin
      rd_data_q   <= rd_data_d;
      rd_valid_q  <= rd_valid_d;
      rd_zero_q   <= (rd_data_d == {DW{1'b0}});
      pend_q      <= accept_s & (bus.cmd_op == OP_ADD);
      pend_addr_q <= bus.cmd_addr;
      case (state_q)
        ST_CLEAR: begin
          sweep_cnt_q <= sweep_cnt_q + AW'(1);
          if (sweep_cnt_q == {AW{1'b1}}) begin
            state_q <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (bus.clear_req) begin
            state_q     <= ST_CLEAR;
            sweep_cnt_q <= {AW{1'b0}};
          end
        end
        default: begin
          state_q     <= ST_CLEAR;
          sweep_cnt_q <= {AW{1'b0}};
        end
      endcase
    end
  end

  // Tape storage: sweep writes, ADD write-back, then WRITE so a colliding WRITE wins.
  always_ff @(posedge clk) begin
    if (state_q == ST_CLEAR) begin
      mem_q[sweep_cnt_q] <= INIT_VAL;
    end else begin
      if (pend_q) begin
        mem_q[pend_addr_q] <= rd_data_q;
      end
      if (accept_s && (bus.cmd_op == OP_WRITE)) begin
        mem_q[bus.cmd_addr] <= bus.cmd_data;
      end
    end
  end
endmodule
